tick_timer_sched: RTL

Multi-channel timeout scheduler for the RVM control logic. An internal prescaler divides the system clock into a periodic tick. NUM_CH requesters load countdown timers through one round-robin arbitrated load port. A sweep FSM decrements all timers with a single shared decrementer, one channel per cycle after each tick, and pulses done when a timer expires.

---
 rtl/tick_timer_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tick_timer_sched.sv
// Multi-channel tick-based timeout scheduler: prescaled tick, round-robin
// load arbiter and a one-channel-per-cycle sweep with a shared decrementer.
module tick_timer_sched #(
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 250000,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      clk_reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*CNT_W-1:0]   req_ticks,
    input  logic [NUM_CH-1:0]         cancel,
    output logic [NUM_CH-1:0]         grant,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic                      tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_CH);

    typedef enum logic {
        S_WAIT,
        S_SWEEP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [CNT_W-1:0]  rem_q [NUM_CH];
    logic [CNT_W-1:0]  rem_d [NUM_CH];

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] grant_c;
    logic              arb_en;
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [CNT_W-1:0]  win_ticks;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (cnt_q == PW'(PRESCALE - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Loads are only accepted while idle between sweeps.
    assign arb_en = (state_q == S_WAIT) && !tick_q;
    assign elig   = req & ~busy_q & ~cancel;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        grant_c = '0;
        if (arb_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!win_vld && elig[(int'(rr_q) + k) % NUM_CH]) begin
                    win_vld = 1'b1;
                    win_idx = IW'((int'(rr_q) + k) % NUM_CH);
                end
            end
        end
        if (win_vld) begin
            grant_c[win_idx] = 1'b1;
        end
    end

    assign win_ticks = req_ticks[win_idx*CNT_W +: CNT_W];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        busy_d  = busy_q;
        done_d  = '0;
        rem_d   = rem_q;
        unique case (state_q)
            S_WAIT: begin
                if (tick_q) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end else if (win_vld) begin
                    rr_d = (win_idx == IW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
                    rem_d[win_idx] = win_ticks;
                    if (win_ticks != '0) begin
                        busy_d[win_idx] = 1'b1;
                    end else begin
                        done_d[win_idx] = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                if (busy_q[idx_q] && !cancel[idx_q]) begin
                    rem_d[idx_q] = rem_q[idx_q] - 1'b1;
                    if (rem_q[idx_q] == CNT_W'(1)) begin
                        busy_d[idx_q] = 1'b0;
                        done_d[idx_q] = 1'b1;
                    end
                end
                if (idx_q == IW'(NUM_CH - 1)) begin
                    state_d = S_WAIT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
                idx_d   = '0;
            end
        endcase
        // Cancel overrides both loads and expiries.
        for (int i = 0; i < NUM_CH; i++) begin
            if (cancel[i]) begin
                busy_d[i] = 1'b0;
                rem_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge clk_reset) begin
        if (clk_reset) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            idx_q   <= '0;
            rr_q    <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_CH; i++) begin
                rem_q[i] <= rem_d[i];
            end
        end
    end

    assign grant = clk_reset ? '0 : grant_c;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tick  = tick_q;

endmodule
